// File: rtl/ham_enc_stream.sv
// Streaming extended-Hamming (SECDED) encoder: 4/11/26 info bits -> 8/16/32-bit codewords, two-stage valid/ready pipe.
// Optional HAM_ENC_ERR_INJECT_EN adds inj_mask, captured with the word and XORed into the codeword as S2 loads.
module ham_enc_stream #(
   parameter int MAX_CODEWORD_WIDTH = 32,
   parameter int MAX_INFO_WIDTH     = 26,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [MAX_INFO_WIDTH-1:0]     data_in,
   input  logic [1:0]                    mod,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
   output logic [1:0]                    out_mod,
   output logic                          out_valid,
   input  logic                          out_ready,
`ifdef HAM_ENC_ERR_INJECT_EN
   input  logic [MAX_CODEWORD_WIDTH-1:0] inj_mask,
`endif
   output logic [CNT_WIDTH-1:0]          word_count,
   output logic                          mode_err
);

   typedef enum logic [1:0] {
      MODE_4   = 2'b00,
      MODE_11  = 2'b01,
      MODE_26  = 2'b10,
      MODE_BAD = 2'b11
   } mode_t;

   mode_t                         in_mod;
   logic [25:0]                   info_mask;
   logic [25:0]                   in_info;
   logic                          s1_valid;
   logic [25:0]                   s1_info;
   mode_t                         s1_mod;
   logic                          s2_load;
   logic [4:0]                    syn;
   logic [4:0]                    pos_j;
   logic                          ovp;
   logic [31:0]                   cw;
   logic [MAX_CODEWORD_WIDTH-1:0] cw_out;
`ifdef HAM_ENC_ERR_INJECT_EN
   logic [MAX_CODEWORD_WIDTH-1:0] s1_inj;
   logic [31:0]                   len_mask;
`endif

   always_comb begin
      in_mod = mode_t'(mod);
      unique case (in_mod)
         MODE_4:  info_mask = 26'h000000F;
         MODE_11: info_mask = 26'h00007FF;
         MODE_26: info_mask = 26'h3FFFFFF;
         default: info_mask = '0;
      endcase
      in_info = data_in[25:0] & info_mask;
   end

   assign s2_load  = !out_valid || out_ready;
   assign in_ready = !rst && (!s1_valid || s2_load);

   // Info bits above k are already zero in S1, so XOR-ing the positions of all set
   // info bits yields the check bits for every mode at once.
   always_comb begin
      syn   = '0;
      pos_j = '0;
      for (int unsigned pos = 3; pos < 32; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (s1_info[pos_j]) syn = syn ^ pos[4:0];
            pos_j = pos_j + 5'd1;
         end
      end
      ovp = (^s1_info) ^ (^syn);

      unique case (s1_mod)
         MODE_4:  cw = {24'b0, s1_info[3:0],  ovp, syn[2:0]};
         MODE_11: cw = {16'b0, s1_info[10:0], ovp, syn[3:0]};
         MODE_26: cw = {s1_info[25:0], ovp, syn[4:0]};
         default: cw = '0;
      endcase

      cw_out = '0;
`ifdef HAM_ENC_ERR_INJECT_EN
      unique case (s1_mod)
         MODE_4:  len_mask = 32'h0000_00FF;
         MODE_11: len_mask = 32'h0000_FFFF;
         MODE_26: len_mask = 32'hFFFF_FFFF;
         default: len_mask = '0;
      endcase
      cw_out[31:0] = cw ^ (s1_inj[31:0] & len_mask);
`else
      cw_out[31:0] = cw;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_info    <= '0;
         s1_mod     <= MODE_4;
         out_valid  <= 1'b0;
         data_out   <= '0;
         out_mod    <= '0;
         word_count <= '0;
         mode_err   <= 1'b0;
`ifdef HAM_ENC_ERR_INJECT_EN
         s1_inj     <= '0;
`endif
      end else begin
         if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_info  <= in_info;
            s1_mod   <= in_mod;
`ifdef HAM_ENC_ERR_INJECT_EN
            s1_inj   <= inj_mask;
`endif
            if (in_mod == MODE_BAD) mode_err <= 1'b1;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end

         if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               data_out <= cw_out;
               out_mod  <= s1_mod;
            end
         end

         if (out_valid && out_ready) word_count <= word_count + CNT_WIDTH'(1);
      end
   end

endmodule
